// File: rtl/fetch_sequencer_pkg.sv
// Shared fetch-sequencer definitions: IM base/vector addresses, sequencer state
// encoding and the redirect-source enum consumed by the hazard unit.
package fetch_sequencer_pkg;

  localparam logic [31:0] RESET_PC_DEF = 32'h0000_3000;
  localparam logic [31:0] EXC_PC_DEF   = 32'h0000_4180;

  typedef enum logic [1:0] {
    ST_BOOT = 2'd0,
    ST_RUN  = 2'd1,
    ST_SLOT = 2'd2
  } state_t;

  typedef enum logic [2:0] {
    SRC_NONE = 3'd0,
    SRC_EXC  = 3'd1,
    SRC_ERET = 3'd2,
    SRC_JR   = 3'd3,
    SRC_J    = 3'd4,
    SRC_BR   = 3'd5
  } src_t;

  // Wrapping subtract makes addresses below base look huge, so one compare covers both ends.
  function automatic logic in_im(input logic [31:0] addr, input logic [31:0] base,
                                 input int unsigned aw);
    logic [31:0] off;
    off = addr - base;
    return (off >> (aw + 2)) == 32'd0;
  endfunction

endpackage

// File: rtl/fetch_sequencer_npc_select.sv
// Combinational redirect arbiter: picks the highest-priority enabled request,
// forms its target and flags targets that are misaligned or outside IM.
module fetch_sequencer_npc_select
  import fetch_sequencer_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEF,
  parameter logic [31:0] EXC_PC   = EXC_PC_DEF,
  parameter int unsigned IM_AW    = 12
) (
  input  logic        i_en_vec,
  input  logic        i_en_flow,
  input  logic [3:0]  i_pc_hi,
  input  logic        i_exc_req,
  input  logic        i_eret_req,
  input  logic [31:0] i_epc,
  input  logic        i_jr_req,
  input  logic [31:0] i_jr_target,
  input  logic        i_j_req,
  input  logic [25:0] i_j_index,
  input  logic        i_br_req,
  input  logic [31:0] i_br_target,
  output logic        o_accept,
  output src_t        o_src,
  output logic [31:0] o_target,
  output logic        o_err
);

  logic [31:0] w_j_target;

  assign w_j_target = {i_pc_hi, i_j_index, 2'b00};

  always_comb begin
    o_accept = 1'b0;
    o_src    = SRC_NONE;
    o_target = EXC_PC;
    o_err    = 1'b0;
    if (i_en_vec && i_exc_req) begin
      o_accept = 1'b1;
      o_src    = SRC_EXC;
      o_target = EXC_PC;
    end else if (i_en_vec && i_eret_req) begin
      o_accept = 1'b1;
      o_src    = SRC_ERET;
      o_target = i_epc;
      o_err    = (i_epc[1:0] != 2'b00) || !in_im(i_epc, RESET_PC, IM_AW);
    end else if (i_en_flow && i_jr_req) begin
      o_accept = 1'b1;
      o_src    = SRC_JR;
      o_target = i_jr_target;
      o_err    = (i_jr_target[1:0] != 2'b00) || !in_im(i_jr_target, RESET_PC, IM_AW);
    end else if (i_en_flow && i_j_req) begin
      // j targets are word-aligned by construction; only range can go wrong.
      o_accept = 1'b1;
      o_src    = SRC_J;
      o_target = w_j_target;
      o_err    = !in_im(w_j_target, RESET_PC, IM_AW);
    end else if (i_en_flow && i_br_req) begin
      o_accept = 1'b1;
      o_src    = SRC_BR;
      o_target = i_br_target;
      o_err    = (i_br_target[1:0] != 2'b00) || !in_im(i_br_target, RESET_PC, IM_AW);
    end
  end

endmodule

// File: rtl/fetch_sequencer.sv
// Program-counter owner: sequences BOOT/RUN/SLOT, applies stall, accepted
// redirects and the optional branch delay slot, and drives the IM word index.
//   state | meaning
//   BOOT  | just out of reset, pc=RESET_PC not yet fetchable
//   RUN   | normal sequential fetch, all redirects accepted
//   SLOT  | delay-slot fetch issued, pending target lands next unstalled edge
module fetch_sequencer
  import fetch_sequencer_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = RESET_PC_DEF,
  parameter logic [31:0] EXC_PC     = EXC_PC_DEF,
  parameter int unsigned IM_AW      = 12,
  parameter bit          DELAY_SLOT = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             stall,
  input  logic             exc_req,
  input  logic             eret_req,
  input  logic [31:0]      epc,
  input  logic             jr_req,
  input  logic [31:0]      jr_target,
  input  logic             j_req,
  input  logic [25:0]      j_index,
  input  logic             br_req,
  input  logic [31:0]      br_target,
  output logic [31:0]      pc,
  output logic [IM_AW-1:0] instr_addr,
  output logic             pc_valid,
  output logic             redirect,
  output logic             addr_err
);

  state_t      r_state, w_state_nxt;
  logic [31:0] r_pc, w_pc_nxt;
  logic [31:0] r_pending, w_pending_nxt;
  logic [31:0] w_pc_plus4;
  logic [31:0] w_offset;
  logic        w_en_vec, w_en_flow;
  logic        w_accept, w_err;
  src_t        w_src;
  logic [31:0] w_target;

  assign w_pc_plus4 = r_pc + 32'd4;
  assign w_offset   = r_pc - RESET_PC;
  assign w_en_vec   = !stall && (r_state != ST_BOOT);
  assign w_en_flow  = !stall && (r_state == ST_RUN);

  fetch_sequencer_npc_select #(
    .RESET_PC (RESET_PC),
    .EXC_PC   (EXC_PC),
    .IM_AW    (IM_AW)
  ) u_npc_select (
    .i_en_vec    (w_en_vec),
    .i_en_flow   (w_en_flow),
    .i_pc_hi     (w_pc_plus4[31:28]),
    .i_exc_req   (exc_req),
    .i_eret_req  (eret_req),
    .i_epc       (epc),
    .i_jr_req    (jr_req),
    .i_jr_target (jr_target),
    .i_j_req     (j_req),
    .i_j_index   (j_index),
    .i_br_req    (br_req),
    .i_br_target (br_target),
    .o_accept    (w_accept),
    .o_src       (w_src),
    .o_target    (w_target),
    .o_err       (w_err)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= ST_BOOT;
      r_pc      <= RESET_PC;
      r_pending <= RESET_PC;
    end else begin
      r_state   <= w_state_nxt;
      r_pc      <= w_pc_nxt;
      r_pending <= w_pending_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_pc_nxt      = r_pc;
    w_pending_nxt = r_pending;
    case (r_state)
      ST_BOOT: w_state_nxt = ST_RUN;
      ST_RUN, ST_SLOT: begin
        if (stall) begin
          w_state_nxt = r_state;
        end else if (w_accept) begin
          // Vectors, eret and bad targets never go through a delay slot.
          if (w_err) begin
            w_pc_nxt    = EXC_PC;
            w_state_nxt = ST_RUN;
          end else if (!DELAY_SLOT || w_src == SRC_EXC || w_src == SRC_ERET) begin
            w_pc_nxt    = w_target;
            w_state_nxt = ST_RUN;
          end else begin
            w_pc_nxt      = w_pc_plus4;
            w_pending_nxt = w_target;
            w_state_nxt   = ST_SLOT;
          end
        end else if (r_state == ST_SLOT) begin
          w_pc_nxt    = r_pending;
          w_state_nxt = ST_RUN;
        end else begin
          w_pc_nxt = w_pc_plus4;
        end
      end
      default: begin
        w_state_nxt = ST_BOOT;
        w_pc_nxt    = RESET_PC;
      end
    endcase
  end

  assign pc         = r_pc;
  assign instr_addr = IM_AW'(w_offset >> 2);
  assign pc_valid   = (r_state != ST_BOOT);
  assign redirect   = w_accept;
  assign addr_err   = w_accept && w_err;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer with DELAY_SLOT=1, IM_AW=12.
module tb_fetch_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall, exc_req, eret_req, jr_req, j_req, br_req;
  logic [31:0] epc, jr_target, br_target;
  logic [25:0] j_index;
  logic [31:0] pc;
  logic [11:0] instr_addr;
  logic        pc_valid, redirect, addr_err;

  int checks = 0;
  int errors = 0;

  fetch_sequencer #(
    .RESET_PC   (32'h0000_3000),
    .EXC_PC     (32'h0000_4180),
    .IM_AW      (12),
    .DELAY_SLOT (1'b1)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .stall      (stall),
    .exc_req    (exc_req),
    .eret_req   (eret_req),
    .epc        (epc),
    .jr_req     (jr_req),
    .jr_target  (jr_target),
    .j_req      (j_req),
    .j_index    (j_index),
    .br_req     (br_req),
    .br_target  (br_target),
    .pc         (pc),
    .instr_addr (instr_addr),
    .pc_valid   (pc_valid),
    .redirect   (redirect),
    .addr_err   (addr_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_reqs();
    stall = 0; exc_req = 0; eret_req = 0; jr_req = 0; j_req = 0; br_req = 0;
  endtask

  initial begin
    reset = 1'b0;
    clear_reqs();
    epc = '0; jr_target = '0; br_target = '0; j_index = '0;
    #12;
    chk("rst_pc", pc, 32'h3000);
    chk("rst_valid", {31'd0, pc_valid}, 32'd0);
    chk("rst_ia", {20'd0, instr_addr}, 32'd0);
    chk("rst_redirect", {31'd0, redirect}, 32'd0);
    reset = 1'b1;

    tick();
    chk("boot_pc", pc, 32'h3000);
    chk("boot_valid", {31'd0, pc_valid}, 32'd1);
    chk("boot_ia", {20'd0, instr_addr}, 32'd0);
    tick();
    chk("seq_pc1", pc, 32'h3004);
    chk("seq_ia1", {20'd0, instr_addr}, 32'd1);
    tick();
    chk("seq_pc2", pc, 32'h3008);
    chk("seq_ia2", {20'd0, instr_addr}, 32'd2);

    // Branch with delay slot
    br_req = 1; br_target = 32'h3020;
    #1 chk("br_redirect", {31'd0, redirect}, 32'd1);
    tick(); clear_reqs();
    chk("br_slot_pc", pc, 32'h300C);
    chk("br_slot_redirect", {31'd0, redirect}, 32'd0);
    tick();
    chk("br_target_pc", pc, 32'h3020);

    // Enter SLOT via jr, then exc+jr+br in slot
    jr_req = 1; jr_target = 32'h3040;
    tick(); clear_reqs();
    chk("jr_slot_pc", pc, 32'h3024);
    exc_req = 1; jr_req = 1; jr_target = 32'h3080; br_req = 1; br_target = 32'h3090;
    #1 chk("exc_redirect", {31'd0, redirect}, 32'd1);
    chk("exc_noerr", {31'd0, addr_err}, 32'd0);
    tick(); clear_reqs();
    chk("exc_pc", pc, 32'h4180);
    tick();
    chk("exc_next_pc", pc, 32'h4184);

    // Target checks
    jr_req = 1; jr_target = 32'h3002;
    #1 chk("jr_misalign_err", {31'd0, addr_err}, 32'd1);
    tick(); clear_reqs();
    chk("jr_misalign_pc", pc, 32'h4180);
    jr_req = 1; jr_target = 32'h7000;
    #1 chk("jr_range_err", {31'd0, addr_err}, 32'd1);
    tick(); clear_reqs();
    chk("jr_range_pc", pc, 32'h4180);
    jr_req = 1; jr_target = 32'h6FFC;
    #1 chk("jr_top_noerr", {31'd0, addr_err}, 32'd0);
    tick(); clear_reqs();
    chk("jr_top_slot", pc, 32'h4184);
    tick();
    chk("jr_top_pc", pc, 32'h6FFC);
    chk("jr_top_ia", {20'd0, instr_addr}, 32'h0FFF);

    // eret lands next edge with no slot
    eret_req = 1; epc = 32'h3010;
    #1 chk("eret_redirect", {31'd0, redirect}, 32'd1);
    tick(); clear_reqs();
    chk("eret_pc", pc, 32'h3010);

    // Stall holds pc and blocks the branch
    stall = 1; br_req = 1; br_target = 32'h3100;
    for (int i = 0; i < 3; i++) begin
      #1 chk("stall_redirect", {31'd0, redirect}, 32'd0);
      tick();
      chk("stall_pc", pc, 32'h3010);
    end
    stall = 0;
    #1 chk("unstall_redirect", {31'd0, redirect}, 32'd1);
    tick(); clear_reqs();
    chk("unstall_slot_pc", pc, 32'h3014);
    tick();
    chk("unstall_target_pc", pc, 32'h3100);

    // jr ignored in SLOT, then async reset mid-SLOT
    jr_req = 1; jr_target = 32'h3200;
    tick(); clear_reqs();
    chk("slot2_pc", pc, 32'h3104);
    jr_req = 1; jr_target = 32'h3300;
    #1 chk("slot_jr_ignored", {31'd0, redirect}, 32'd0);
    clear_reqs();
    #2 reset = 1'b0;
    #1 chk("midslot_rst_pc", pc, 32'h3000);
    chk("midslot_rst_valid", {31'd0, pc_valid}, 32'd0);
    #1 reset = 1'b1;
    tick();
    chk("rst2_boot_pc", pc, 32'h3000);
    tick();
    chk("rst2_pending_lost", pc, 32'h3004);

    // j: in-range and out-of-range
    j_req = 1; j_index = 26'h0000D00;
    #1 chk("j_redirect", {31'd0, redirect}, 32'd1);
    tick(); clear_reqs();
    chk("j_slot_pc", pc, 32'h3008);
    tick();
    chk("j_target_pc", pc, 32'h3400);
    j_req = 1; j_index = 26'h3FFFFFF;
    #1 chk("j_range_err", {31'd0, addr_err}, 32'd1);
    tick(); clear_reqs();
    chk("j_range_pc", pc, 32'h4180);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
